// File: rtl/fifo_word_packer_pkg.sv
// Shared widths for the async FIFO and its read-side word packer.
// Lane, word, keep and lane-count sizes all derive from two constants.
package fifo_pkg;
    localparam int data_width = 8;
    localparam int pack_ratio = 4;
    localparam int word_width = data_width * pack_ratio;
    localparam int keep_width = pack_ratio;
    localparam int cnt_width  = $clog2(pack_ratio + 1);
endpackage

// File: rtl/fifo_word_packer_if.sv
// Packed-word output stream: data, byte-keep mask and valid/ready.
// The packer drives it as master; the DMA/bus side is the slave.
interface fifo_word_packer_if #(
    parameter int data_width = fifo_pkg::data_width,
    parameter int pack_ratio = fifo_pkg::pack_ratio
) ();
    logic [data_width*pack_ratio-1:0] out_data;
    logic [pack_ratio-1:0]            out_keep;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output out_data,
        output out_keep,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_keep,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_word_packer_idle_timer.sv
// Idle counter for the word packer: pulses timeout on the idle cycle
// that reaches flush_timeout; a timeout of 0 never fires.
module idle_timer #(
    parameter int flush_timeout = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    output logic timeout
);
    localparam int tw = (flush_timeout > 0) ? $clog2(flush_timeout + 1) : 1;
    localparam logic [tw-1:0] sat  = tw'(flush_timeout);
    localparam logic [tw-1:0] last =
        (flush_timeout > 0) ? tw'(flush_timeout - 1) : '0;

    logic [tw-1:0] count;

    // Saturates so a timeout held off by a busy slot never wraps around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!idle) begin
            count <= '0;
        end else if (count != sat) begin
            count <= count + tw'(1);
        end
    end

    assign timeout = (flush_timeout != 0) && idle && (count == last);
endmodule

// File: rtl/fifo_word_packer.sv
// Drains 8-bit FIFO entries and packs them little-endian into words;
// partial words close on flush or idle timeout with a byte-keep mask.
module fifo_word_packer #(
    parameter int data_width    = fifo_pkg::data_width,
    parameter int pack_ratio    = fifo_pkg::pack_ratio,
    parameter int flush_timeout = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    input  logic [data_width-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    fifo_word_packer_if.master    word,
    output logic                  protocol_err
);
    localparam int word_width = data_width * pack_ratio;
    localparam int cnt_width  = $clog2(pack_ratio + 1);
    localparam logic [cnt_width-1:0] cnt_full = cnt_width'(pack_ratio);

    logic [word_width-1:0] asm_q;
    logic [word_width-1:0] asm_d;
    logic [cnt_width-1:0]  cnt_q;
    logic [cnt_width-1:0]  cnt_d;
    logic [pack_ratio-1:0] keep_d;
    logic                  inflight;
    logic                  pend_flush;
    logic                  pend_d;
    logic                  take;
    logic                  req;
    logic                  slot_free;
    logic                  close_full;
    logic                  close_part;
    logic                  load;
    logic                  idle;
    logic                  timeout;

    idle_timer #(
        .flush_timeout(flush_timeout)
    ) u_idle (
        .clk    (rd_clk),
        .rst_n  (rst_n),
        .idle   (idle),
        .timeout(timeout)
    );

    assign slot_free = !word.out_valid || word.out_ready;
    assign take      = fifo_valid && inflight && (cnt_q != cnt_full);
    assign req       = flush || pend_flush || timeout;
    assign idle      = (cnt_q != '0) && !fifo_valid && !inflight;

    // Counting the in-flight byte keeps a full word from over-requesting.
    assign fifo_rd_en = rst_n && !fifo_empty && !pend_flush &&
        ((int'(cnt_q) + int'(inflight)) < pack_ratio);

    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        for (int i = 0; i < pack_ratio; i++) begin
            if (take && (int'(cnt_q) == i)) begin
                asm_d[i*data_width +: data_width] = fifo_rdata;
            end
        end
        if (take) begin
            cnt_d = cnt_q + cnt_width'(1);
        end
        keep_d = '0;
        for (int i = 0; i < pack_ratio; i++) begin
            keep_d[i] = (i < int'(cnt_d));
        end
    end

    assign close_full = (cnt_d == cnt_full);
    assign close_part = req && !inflight && (cnt_q != '0);
    assign load       = (close_full || close_part) && slot_free;

    // A flush racing a full word lands on the empty next word: drop it.
    always_comb begin
        pend_d = 1'b0;
        if (load || close_full) begin
            pend_d = 1'b0;
        end else if (req && inflight) begin
            pend_d = 1'b1;
        end else if (req && (cnt_q != '0)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q          <= '0;
            cnt_q          <= '0;
            inflight       <= 1'b0;
            pend_flush     <= 1'b0;
            protocol_err   <= 1'b0;
            word.out_data  <= '0;
            word.out_keep  <= '0;
            word.out_valid <= 1'b0;
        end else begin
            inflight   <= fifo_rd_en;
            pend_flush <= pend_d;
            if (fifo_valid && !inflight) begin
                protocol_err <= 1'b1;
            end
            if (load) begin
                word.out_data  <= asm_d;
                word.out_keep  <= keep_d;
                word.out_valid <= 1'b1;
                asm_q          <= '0;
                cnt_q          <= '0;
            end else begin
                asm_q <= asm_d;
                cnt_q <= cnt_d;
                if (word.out_ready) begin
                    word.out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer of the asynchronous FIFO. Runs in the FIFO read clock domain, drains 8-bit entries through the FIFO's `rd_en`/`valid`/`rdata` port, and packs them little-endian into 32-bit words on a valid/ready output stream. Partial words are closed by an idle timeout or an explicit flush and carry a byte-keep mask. Downstream logic (DMA/bus master) sees only whole-word transfers.

## Interface
- `data_width`, 8: FIFO entry width (bits per lane)
- `pack_ratio`, 4: lanes per output word; output width = `data_width*pack_ratio`
- `flush_timeout`, 16: idle cycles before a partial word is auto-closed; 0 disables auto-close
- `rd_clk`  in  1  clock (FIFO read clock); all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_valid`  in  1  FIFO read-data valid (one cycle after an accepted `rd_en`)
- `fifo_rdata`  in  `data_width`  FIFO read data, qualified by `fifo_valid`
- `fifo_rd_en`  out  1  read request to FIFO
- `flush`  in  1  single-cycle request: close current partial word
- `out_data`  out  `data_width*pack_ratio`  packed word; lane 0 = first byte, in bits [7:0]
- `out_keep`  out  `pack_ratio`  lane-valid mask; all ones for full words
- `out_valid`  out  1  word available
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`
- `protocol_err`  out  1  sticky: `fifo_valid` seen with no read in flight

## Operation
- State: assembly register `asm`, lane count `cnt` (0..pack_ratio), `inflight` (= previous-cycle `fifo_rd_en`), output register (`out_data`, `out_keep`, `out_valid`), idle counter.
- `fifo_rd_en = !fifo_empty && !pend_flush && (cnt + inflight) < pack_ratio`; combinational from registered state and `fifo_empty`.
- Byte arrival (`fifo_valid`): written into lane `cnt`, `cnt` increments.
- Word close condition: `cnt` reaches `pack_ratio` with the arriving byte, or a flush/timeout with `cnt > 0` and `inflight == 0`.
- Close executes only when output slot is free (`!out_valid || out_ready`): load `out_data` (unfilled lanes zero), `out_keep` = lanes filled, `out_valid` = 1, `cnt` = 0. Otherwise hold: full word stays at `cnt = pack_ratio` (rd_en gated off); pending flush stays latched in `pend_flush`.
- `flush` with `inflight == 1`: latched; closes after the in-flight byte lands, that byte included.
- `flush` or timeout with `cnt == 0`: no word emitted, `pend_flush` cleared.
- Idle counter: counts cycles with `cnt > 0`, no `fifo_valid`, no `inflight`; cleared otherwise; at `flush_timeout` acts as flush.
- Output register holds data/keep stable while `out_valid && !out_ready`.
- `fifo_valid` while `inflight == 0`: byte dropped, `protocol_err` set until reset.

## Timing
- Reset (async, `rst_n` low): `fifo_rd_en`=0 (forced), `out_valid`=0, `out_data`=0, `out_keep`=0, `protocol_err`=0, `cnt`=0, `inflight`=0, `pend_flush`=0, idle counter 0.
- Reset mid-word discards partial data; no word emitted.
- Latency: last lane `fifo_valid` at edge N → `out_valid` high after edge N+1 (slot free).
- Sustained throughput with FIFO non-empty and `out_ready` high: 4 bytes per 5 cycles (rd_en low one cycle per word).
- Flush sampled at edge N with `cnt > 0`, `inflight == 0`, slot free → `out_valid` after edge N+1.
- Simultaneous full-word close and `flush`: full word emitted, flush applies to next (empty) word → no-op.
- `out_ready` with `!out_valid` ignored.

## Structure
- Package `fifo_pkg`: `data_width`, `pack_ratio`, derived word width, keep-width and `cnt` width constants shared with the FIFO.
- One sub-module natural: `idle_timer` (idle counter + timeout pulse, parameterised by `flush_timeout`).

## Test plan
- Write 0x11,0x22,0x33,0x44 to FIFO, `out_ready`=1 → one word 0x44332211, keep 4'b1111, rd_en pattern 1,1,1,1,0.
- Write 0xAA,0xBB then stop, `flush_timeout`=16 → after 16 idle cycles word 0x0000BBAA, keep 4'b0011.
- 12 bytes with `out_ready`=0 for 20 cycles → first word held stable, second complete at `cnt`=4, `fifo_rd_en` low, release → three words in order, no loss.
- `flush` pulse same cycle as second byte's rd_en → word holds both bytes, keep 4'b0011.
- Force `fifo_valid` with no prior rd_en → `protocol_err`=1 sticky, byte not packed.
- Assert `rst_n` low with 3 lanes filled → all outputs 0 immediately; after release next 4 bytes form a clean full word.
